// File: rtl/scratchpad_scrub_ram.sv
// rtl/scratchpad_scrub_ram.sv - TL-UL scratchpad RAM with credit backpressure, request denial and zeroize FSM
module scratchpad_scrub_ram #(
    parameter int unsigned     AW        = 32,
    parameter logic [AW-1:0]   ADDRESS   = '0,
    parameter int unsigned     DEPTH     = 256,
    parameter int unsigned     DW        = 64,
    parameter int unsigned     AIW       = 8,
    parameter int unsigned     SZW       = 3,
    parameter int unsigned     RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        a_opcode,
    input  logic [SZW-1:0]    a_size,
    input  logic [AIW-1:0]    a_source,
    input  logic [AW-1:0]     a_address,
    input  logic [DW/8-1:0]   a_mask,
    input  logic [DW-1:0]     a_data,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [2:0]        d_opcode,
    output logic [SZW-1:0]    d_size,
    output logic [AIW-1:0]    d_source,
    output logic              d_denied,
    output logic [DW-1:0]     d_data,
    output logic              d_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    input  logic              scrub_req,
    output logic              scrub_busy,
    output logic              scrub_done
);
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned WORDS = DEPTH / NB;
    localparam int unsigned OFFW  = $clog2(NB);
    localparam int unsigned IW    = $clog2(WORDS);
    localparam int unsigned PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW    = CW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SCRUB, ST_DONE} state_t;

    typedef struct packed {
        logic [2:0]     opcode;
        logic [SZW-1:0] size;
        logic [AIW-1:0] source;
        logic           denied;
        logic           corrupt;
        logic [DW-1:0]  data;
    } rsp_t;

    state_t         state;
    logic [IW-1:0]  ctr;

    // Request decode; the borrow of the base subtraction flags addresses below the window
    logic [AW:0]    addr_diff;
    logic [AW-1:0]  word_off;
    logic [IW-1:0]  word_idx;
    logic           below, oob, bad_op, bad_size, denied, is_get, is_put;
    logic           accept, put_we, scrub_we;

    assign addr_diff = {1'b0, a_address} - {1'b0, ADDRESS};
    assign below     = addr_diff[AW];
    assign word_off  = addr_diff[AW-1:0] >> OFFW;
    assign word_idx  = word_off[IW-1:0];
    assign oob       = |(word_off >> IW);
    assign is_get    = (a_opcode == 3'd4);
    assign is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign bad_op    = !(is_get || is_put);
    assign bad_size  = (a_size > SZW'(OFFW));
    assign denied    = bad_op || below || oob || bad_size;
    assign accept    = a_valid && a_ready;
    assign put_we    = accept && is_put && !denied;
    assign scrub_we  = (state == ST_SCRUB);

    logic [DW-1:0]  mem [WORDS];
    logic [DW-1:0]  rdata;

    always_ff @(posedge clk) begin
        if (!rst && scrub_we) begin
            mem[ctr] <= '0;
        end else if (!rst && put_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_mask[i]) mem[word_idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
        rdata <= mem[word_idx];
    end

    logic           s1_valid;
    logic [2:0]     s1_opcode;
    logic [SZW-1:0] s1_size;
    logic [AIW-1:0] s1_source;
    logic           s1_denied;
    logic           s1_data_en;
    rsp_t           s1_rsp;

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_opcode  <= is_get ? 3'd1 : 3'd0;
            s1_size    <= a_size;
            s1_source  <= a_source;
            s1_denied  <= denied;
            s1_data_en <= is_get && !denied;
        end
    end

    always_comb begin
        s1_rsp         = '0;
        s1_rsp.opcode  = s1_opcode;
        s1_rsp.size    = s1_size;
        s1_rsp.source  = s1_source;
        s1_rsp.denied  = s1_denied;
        s1_rsp.corrupt = s1_denied && (s1_opcode == 3'd1);
        s1_rsp.data    = s1_data_en ? rdata : '0;
    end

    // Fall-through response FIFO: an S1 response bypasses storage when the queue is empty and d_ready is high
    rsp_t           fifo [RSP_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           fifo_empty, bypass, push, pop;
    logic [OW-1:0]  occ;
    rsp_t           d_rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign bypass     = s1_valid && fifo_empty && d_ready;
    assign push       = s1_valid && !bypass;
    assign pop        = !fifo_empty && d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= s1_rsp;
    end

    always_comb begin
        d_rsp = '0;
        if (!fifo_empty)   d_rsp = fifo[rd_ptr];
        else if (s1_valid) d_rsp = s1_rsp;
    end

    assign d_valid   = !fifo_empty || s1_valid;
    assign d_opcode  = d_rsp.opcode;
    assign d_size    = d_rsp.size;
    assign d_source  = d_rsp.source;
    assign d_denied  = d_rsp.denied;
    assign d_corrupt = d_rsp.corrupt;
    assign d_data    = d_rsp.data;

    // Credits: every accepted request holds a FIFO slot until its response is consumed
    assign occ     = OW'(count) + OW'(s1_valid);
    assign a_ready = (state == ST_IDLE) && (occ < OW'(RSP_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ctr        <= '0;
            scrub_busy <= 1'b0;
            scrub_done <= 1'b0;
        end else begin
            scrub_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scrub_req) begin
                        state      <= ST_DRAIN;
                        scrub_busy <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ctr <= '0;
                    if (!s1_valid) state <= ST_SCRUB;
                end
                ST_SCRUB: begin
                    if (ctr == IW'(WORDS - 1)) begin
                        state      <= ST_DONE;
                        scrub_done <= 1'b1;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    scrub_busy <= 1'b0;
                    ctr        <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scratchpad_scrub_ram.sv
// tb/tb_scratchpad_scrub_ram.sv - directed scoreboard bench for scratchpad_scrub_ram
module tb_scratchpad_scrub_ram;
    localparam int          DW    = 64;
    localparam int          DEPTH = 256;
    localparam int          WORDS = 32;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk, rst;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_valid, a_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_denied, d_corrupt, d_valid, d_ready;
    logic [63:0] d_data;
    logic        scrub_req, scrub_busy, scrub_done;

    scratchpad_scrub_ram #(.AW(32), .ADDRESS(BASE), .DEPTH(DEPTH), .DW(DW),
                           .AIW(8), .SZW(3), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
        .d_valid(d_valid), .d_ready(d_ready),
        .scrub_req(scrub_req), .scrub_busy(scrub_busy), .scrub_done(scrub_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [7:0]  source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [WORDS];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_req(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                              input logic [7:0] src, input logic [7:0] mask, input logic [63:0] data);
        exp_t e;
        logic den;
        int   idx;
        den = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (addr < BASE) ||
              (addr >= BASE + DEPTH) || (size > 3'd3);
        idx = int'((addr - BASE) >> 3);
        e.opcode  = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size    = size;
        e.source  = src;
        e.denied  = den;
        e.corrupt = den && (op == 3'd4);
        e.data    = '0;
        if (!den && op == 3'd4) e.data = model[idx];
        if (!den && (op == 3'd0 || op == 3'd1)) begin
            for (int b = 0; b < 8; b++)
                if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                        input logic [7:0] src, input logic [7:0] mask, input logic [63:0] data);
        int waited = 0;
        a_opcode = op; a_address = addr; a_size = size;
        a_source = src; a_mask = mask; a_data = data; a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!a_ready) begin
            check("accept_timeout", a_ready, 1'b1);
            @(posedge clk); #1;
            a_valid = 1'b0;
            return;
        end
        expect_req(op, addr, size, src, mask, data);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", sb.size() != 0, 1'b1);
            end else begin
                e = sb.pop_front();
                check($sformatf("rsp src=%0h", e.source),
                      {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data},
                      {e.opcode, e.size, e.source, e.denied, e.corrupt, e.data});
            end
        end
    end

    initial begin
        int accepted, done_at, pulses;
        rst = 1'b1; a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1; scrub_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_d_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data}, '0);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_scrub", {scrub_busy, scrub_done}, 2'b00);
        @(posedge clk); #1;

        // Full put then read-after-write
        send(3'd0, BASE + 32'h8, 3'd3, 8'h01, 8'hFF, 64'hDEAD_BEEF_0123_4567);
        send(3'd4, BASE + 32'h8, 3'd3, 8'h02, 8'h00, 64'h0);
        wait_drain();

        // Partial put over a zeroed word
        send(3'd0, BASE + 32'h18, 3'd3, 8'h03, 8'hFF, 64'h0);
        send(3'd1, BASE + 32'h18, 3'd3, 8'h04, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        send(3'd4, BASE + 32'h18, 3'd3, 8'h05, 8'h00, 64'h0);
        wait_drain();

        // Denials: out of range, bad opcode, below base, oversize; RAM must be untouched
        send(3'd4, BASE + DEPTH, 3'd3, 8'h06, 8'h00, 64'h0);
        send(3'd2, BASE + 32'h8, 3'd3, 8'h07, 8'hFF, 64'h1111_1111_1111_1111);
        send(3'd0, BASE - 32'h8, 3'd3, 8'h08, 8'hFF, 64'h2222_2222_2222_2222);
        send(3'd4, BASE + 32'h8, 3'd4, 8'h09, 8'h00, 64'h0);
        send(3'd4, BASE + 32'h8, 3'd3, 8'h0A, 8'h00, 64'h0);
        wait_drain();

        // Backpressure: d_ready low, ten Gets offered, only RSP_DEPTH accepted
        d_ready = 1'b0;
        accepted = 0;
        a_opcode = 3'd4; a_size = 3'd3; a_mask = '0; a_data = '0;
        for (int k = 0; k < 10; k++) begin
            a_source  = 8'(8'h40 + accepted);
            a_address = BASE + ((accepted % 2 == 1) ? 32'h18 : 32'h8);
            a_valid   = 1'b1;
            @(negedge clk);
            if (a_ready) begin
                expect_req(3'd4, a_address, 3'd3, a_source, 8'h00, 64'h0);
                accepted++;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        check("bp_accepted", accepted, 4);
        check("bp_a_ready", a_ready, 1'b0);
        @(negedge clk);
        check("bp_hold0", {d_valid, d_source, d_data}, {1'b1, sb[0].source, sb[0].data});
        @(negedge clk);
        check("bp_hold1", {d_valid, d_source, d_data}, {1'b1, sb[0].source, sb[0].data});
        @(posedge clk); #1;
        d_ready = 1'b1;
        wait_drain();

        // Fill all words, then scrub
        for (int w = 0; w < WORDS; w++)
            send(3'd0, BASE + 32'(w * 8), 3'd3, 8'(w), 8'hFF, 64'h0101_0101_0101_0101 * 64'(w + 1));
        wait_drain();
        scrub_req = 1'b1;
        @(posedge clk); #1;
        scrub_req = 1'b0;
        done_at = 0; pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("scrub_busy_start", scrub_busy, 1'b1);
                check("scrub_a_ready", a_ready, 1'b0);
            end
            if (scrub_done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
            if (k == 35) check("scrub_busy_end", scrub_busy, 1'b0);
        end
        check("scrub_done_cycle", done_at, 34);
        check("scrub_done_pulses", pulses, 1);
        for (int w = 0; w < WORDS; w++) model[w] = '0;
        @(posedge clk); #1;
        for (int w = 0; w < WORDS; w++)
            send(3'd4, BASE + 32'(w * 8), 3'd3, 8'(8'h80 + w), 8'h00, 64'h0);
        wait_drain();

        // Reset in the middle of a scrub, while word 10 is being cleared
        for (int w = 0; w < 12; w++)
            send(3'd0, BASE + 32'(w * 8), 3'd3, 8'(w), 8'hFF, 64'hCAFE_0000_0000_0000 | 64'(w + 1));
        send(3'd0, BASE + 32'(20 * 8), 3'd3, 8'd20, 8'hFF, 64'hCAFE_0000_0000_0014);
        wait_drain();
        scrub_req = 1'b1;
        @(posedge clk); #1;
        scrub_req = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_scrub_busy", scrub_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_scrub_busy", scrub_busy, 1'b0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (scrub_done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        check("rst_a_ready_after", a_ready, 1'b1);
        for (int w = 0; w < 10; w++) model[w] = '0;
        @(posedge clk); #1;
        for (int w = 0; w < 10; w++)
            send(3'd4, BASE + 32'(w * 8), 3'd3, 8'(8'hC0 + w), 8'h00, 64'h0);
        send(3'd4, BASE + 32'(11 * 8), 3'd3, 8'hCB, 8'h00, 64'h0);
        send(3'd4, BASE + 32'(20 * 8), 3'd3, 8'hD4, 8'h00, 64'h0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
